// File: rtl/dlx_pkg.sv
// dlx_pkg: definitions shared by the stage sequencer and its wait timer.
//   stage_t          - sequencer state encoding
//   TIMEOUT_DEFAULT  - default number of ready-low wait cycles before a fault
//   WAIT_W           - width of the wait and stall counters
//   sat_inc16()      - saturating 16-bit increment
package dlx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEMACC = 3'd4,
    ST_WRBACK = 3'd5,
    ST_FAULT  = 3'd6
  } stage_t;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int          WAIT_W          = 16;

  function automatic logic [WAIT_W-1:0] sat_inc16(input logic [WAIT_W-1:0] v);
    return (v == {WAIT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// wait_timer: 16-bit wait counter with terminal-count compare.
//   clk      - clock
//   reset    - synchronous active-high reset, clears the count
//   clr      - clear the count (held while the sequencer is not waiting)
//   inc      - count one ready-low wait cycle
//   terminal - count currently equals TIMEOUT
module wait_timer
  import dlx_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic terminal
);

  localparam logic [WAIT_W-1:0] TERM_COUNT = WAIT_W'(TIMEOUT);

  logic [WAIT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      // Saturate so a 65535 timeout can never wrap past its own compare.
      count_reg <= sat_inc16(count_reg);
    end
  end

  assign terminal = (count_reg == TERM_COUNT);

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle instruction stage sequencer
// (FETCH -> DECODE -> EXEC -> [MEMACC] -> WRBACK) with memory wait timeout.
//   clk, reset           - clock, synchronous active-high reset
//   run                  - 1 = execute, 0 = stop at next instruction boundary
//   halt_req             - sampled in WRBACK, returns to IDLE
//   i_ready / d_ready    - instruction / data memory acknowledge
//   d_load_enable,
//   d_write_enable       - registered decoder outputs, valid from EXEC on
//   IF ID EX MEM WB      - one-hot stage strobes
//   i_req, d_req, d_we   - memory requests and write qualifier
//   pc_write             - PC update strobe (WRBACK)
//   busy, fault          - activity and sticky timeout status
//   instr_count          - retired instructions (wrapping)
//   stall_count          - ready-low wait cycles (saturating)
module stage_sequencer
  import dlx_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        halt_req,
  input  logic        i_ready,
  input  logic        d_ready,
  input  logic        d_load_enable,
  input  logic        d_write_enable,
  output logic        IF,
  output logic        ID,
  output logic        EX,
  output logic        MEM,
  output logic        WB,
  output logic        i_req,
  output logic        d_req,
  output logic        d_we,
  output logic        pc_write,
  output logic        busy,
  output logic        fault,
  output logic [31:0] instr_count,
  output logic [15:0] stall_count
);

  stage_t      state_reg, state_next;
  logic        we_reg;
  logic [31:0] instr_count_reg;
  logic [15:0] stall_count_reg;

  logic waiting;
  logic ready_sel;
  logic stall_inc;
  logic wait_terminal;

  // Only FETCH and MEMACC wait on a ready; the acknowledge of the other
  // memory is ignored by construction of this mux.
  assign waiting   = (state_reg == ST_FETCH) || (state_reg == ST_MEMACC);
  assign ready_sel = (state_reg == ST_FETCH) ? i_ready : d_ready;
  assign stall_inc = waiting && !ready_sel;

  // Holding the timer clear outside the wait states guarantees a zero
  // count on every entry to FETCH or MEMACC.
  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (!waiting),
    .inc      (stall_inc),
    .terminal (wait_terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Ready takes priority over the terminal count in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (run) state_next = ST_FETCH;
      ST_FETCH: begin
        if (i_ready)            state_next = ST_DECODE;
        else if (wait_terminal) state_next = ST_FAULT;
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC:   state_next = (d_load_enable || d_write_enable) ? ST_MEMACC : ST_WRBACK;
      ST_MEMACC: begin
        if (d_ready)            state_next = ST_WRBACK;
        else if (wait_terminal) state_next = ST_FAULT;
      end
      ST_WRBACK: state_next = (halt_req || !run) ? ST_IDLE : ST_FETCH;
      ST_FAULT:  state_next = ST_FAULT;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Capture the store qualifier in EXEC so d_we depends on state only.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg <= 1'b0;
    end else if (state_reg == ST_EXEC) begin
      we_reg <= d_write_enable;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count_reg <= '0;
      stall_count_reg <= '0;
    end else begin
      if (state_reg == ST_WRBACK) begin
        instr_count_reg <= instr_count_reg + 32'd1;
      end
      if (stall_inc) begin
        stall_count_reg <= sat_inc16(stall_count_reg);
      end
    end
  end

  always_comb begin
    IF       = 1'b0;
    ID       = 1'b0;
    EX       = 1'b0;
    MEM      = 1'b0;
    WB       = 1'b0;
    i_req    = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    pc_write = 1'b0;
    busy     = 1'b0;
    fault    = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        IF    = 1'b1;
        i_req = 1'b1;
        busy  = 1'b1;
      end
      ST_DECODE: begin
        ID   = 1'b1;
        busy = 1'b1;
      end
      ST_EXEC: begin
        EX   = 1'b1;
        busy = 1'b1;
      end
      ST_MEMACC: begin
        MEM   = 1'b1;
        d_req = 1'b1;
        d_we  = we_reg;
        busy  = 1'b1;
      end
      ST_WRBACK: begin
        WB       = 1'b1;
        pc_write = 1'b1;
        busy     = 1'b1;
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign instr_count = instr_count_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed stimulus with a write-back scoreboard.
// Each expected retirement is queued when its stimulus is issued; a monitor
// pops and compares on every WB strobe.
module tb_stage_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        halt_req;
  logic        i_ready;
  logic        d_ready;
  logic        d_load_enable;
  logic        d_write_enable;
  logic        IF, ID, EX, MEM, WB;
  logic        i_req, d_req, d_we, pc_write, busy, fault;
  logic [31:0] instr_count;
  logic [15:0] stall_count;

  stage_sequencer #(
    .TIMEOUT (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .halt_req       (halt_req),
    .i_ready        (i_ready),
    .d_ready        (d_ready),
    .d_load_enable  (d_load_enable),
    .d_write_enable (d_write_enable),
    .IF             (IF),
    .ID             (ID),
    .EX             (EX),
    .MEM            (MEM),
    .WB             (WB),
    .i_req          (i_req),
    .d_req          (d_req),
    .d_we           (d_we),
    .pc_write       (pc_write),
    .busy           (busy),
    .fault          (fault),
    .instr_count    (instr_count),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] icount;
    logic [15:0] stall;
    int          mem_cycles;
    logic        dwe;
    int          cycles;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int vectors;
  int miscompares;

  logic [10:0] outs;
  assign outs = {IF, ID, EX, MEM, WB, i_req, d_req, d_we, pc_write, busy, fault};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic sig_sel(input int sel);
    case (sel)
      0:       return IF;
      1:       return EX;
      2:       return MEM;
      3:       return WB;
      4:       return !busy;
      default: return fault;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string name);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      hit = sig_sel(sel);
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_%s: not seen within 60 cycles, required 1", name);
    end
  endtask

  function automatic wb_exp_t mk(input logic [31:0] ic, input logic [15:0] st,
                                 input int mc, input logic we, input int cy);
    wb_exp_t e;
    e.icount = ic; e.stall = st; e.mem_cycles = mc; e.dwe = we; e.cycles = cy;
    return e;
  endfunction

  // Monitor: per-cycle strobe exclusivity, per-instruction WB scoreboard.
  initial begin : monitor
    int      cyc;
    int      memc;
    logic    dwe_seen;
    wb_exp_t e;
    cyc = 0; memc = 0; dwe_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0; memc = 0; dwe_seen = 1'b0;
      end else begin
        if (!$onehot0({IF, ID, EX, MEM, WB})) begin
          vectors++;
          miscompares++;
          $display("FAIL strobe_onehot: got %b required at most one high", {IF, ID, EX, MEM, WB});
        end
        if (busy) cyc++;
        if (MEM) begin
          memc++;
          dwe_seen = dwe_seen | d_we;
        end
        if (WB) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_wb: got WB with instr_count %0d, required no retirement", instr_count);
          end else begin
            e = exp_q.pop_front();
            check("wb_instr_count", instr_count, e.icount);
            check("wb_stall_count", 32'(stall_count), 32'(e.stall));
            check("wb_mem_cycles", 32'(memc), 32'(e.mem_cycles));
            check("wb_d_we", 32'(dwe_seen), 32'(e.dwe));
            check("wb_cycles", 32'(cyc), 32'(e.cycles));
            check("wb_pc_write", 32'(pc_write), 32'd1);
          end
          cyc = 0; memc = 0; dwe_seen = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; run = 1'b0; halt_req = 1'b0; i_ready = 1'b0; d_ready = 1'b0;
    d_load_enable = 1'b0; d_write_enable = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_instr_count", instr_count, 32'd0);
    check("reset_stall_count", 32'(stall_count), 32'd0);

    // ALU stream: 4-cycle instructions, 3 retired after 12 cycles
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'(i), 16'd0, 0, 1'b0, 4));
    @(posedge clk);
    #1 reset = 1'b0; run = 1'b1; i_ready = 1'b1;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("alu_instr_count_12cyc", instr_count, 32'd3);
    run = 1'b0;
    wait_for(4, "idle_alu");

    // Load with 3 d_ready-low cycles; run drops mid-MEMACC
    exp_q.push_back(mk(32'd4, 16'd3, 4, 1'b0, 8));
    run = 1'b1; d_load_enable = 1'b1; d_ready = 1'b0;
    wait_for(2, "mem_load");
    repeat (3) @(posedge clk);
    #1 d_ready = 1'b1; run = 1'b0;
    wait_for(4, "idle_load");
    d_load_enable = 1'b0;
    check("load_stall_count", 32'(stall_count), 32'd3);

    // Store, then ALU with halt during the second WB
    exp_q.push_back(mk(32'd5, 16'd3, 1, 1'b1, 5));
    exp_q.push_back(mk(32'd6, 16'd3, 0, 1'b0, 4));
    d_write_enable = 1'b1; d_ready = 1'b1; run = 1'b1;
    wait_for(3, "wb_store");
    d_write_enable = 1'b0;
    wait_for(3, "wb_second");
    halt_req = 1'b1;
    @(negedge clk);
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_instr_count", instr_count, 32'd7);
    halt_req = 1'b0; run = 1'b0;

    // run falls mid-EXEC: instruction still retires
    exp_q.push_back(mk(32'd7, 16'd3, 0, 1'b0, 4));
    run = 1'b1;
    wait_for(1, "ex_runlow");
    run = 1'b0;
    wait_for(4, "idle_runlow");
    check("runlow_instr_count", instr_count, 32'd8);

    // i_ready rises on the terminal FETCH cycle: no fault
    exp_q.push_back(mk(32'd8, 16'd7, 0, 1'b0, 8));
    i_ready = 1'b0; run = 1'b1;
    wait_for(0, "if_term");
    repeat (4) @(posedge clk);
    #1 i_ready = 1'b1; run = 1'b0;
    wait_for(4, "idle_term");
    check("term_fault", 32'(fault), 32'd0);
    check("term_stall_count", 32'(stall_count), 32'd7);

    // i_ready stuck low: fault after the 5th FETCH cycle, sticky
    i_ready = 1'b0; run = 1'b1;
    wait_for(0, "if_timeout");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (fault) break;
    end
    check("timeout_cycles", 32'(n), 32'd5);
    check("fault_outs", 32'(outs), 32'd1);
    check("fault_stall_count", 32'(stall_count), 32'd12);
    check("fault_instr_count", instr_count, 32'd9);
    i_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("fault_sticky_outs", 32'(outs), 32'd1);
    check("fault_sticky_stall", 32'(stall_count), 32'd12);

    // Reset out of FAULT
    reset = 1'b1; run = 1'b0;
    @(negedge clk);
    check("fault_reset_outs", 32'(outs), 32'd0);
    check("fault_reset_instr_count", instr_count, 32'd0);

    // Reset during a stalled store: request drops, nothing retires
    reset = 1'b0; run = 1'b1; i_ready = 1'b1; d_write_enable = 1'b1; d_ready = 1'b0;
    wait_for(2, "mem_store_reset");
    check("store_d_we", 32'(d_we), 32'd1);
    check("store_d_req", 32'(d_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("memreset_outs", 32'(outs), 32'd0);
    check("memreset_instr_count", instr_count, 32'd0);
    check("memreset_stall_count", 32'(stall_count), 32'd0);
    reset = 1'b0; run = 1'b0; d_write_enable = 1'b0;
    repeat (4) @(negedge clk);
    check("memreset_idle_outs", 32'(outs), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
